// File: rtl/pwm_meter_if.sv
// Measurement bus of the PWM meter: the signal under test and the measurement results.
interface pwm_meter_if #(
  parameter int CNT_W = 26
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;
  logic             level;

  modport master (output pwm_in, input high_cnt, period_cnt, meas_valid, timeout, level);
  modport slave  (input pwm_in, output high_cnt, period_cnt, meas_valid, timeout, level);
endinterface

// File: rtl/pwm_meter.sv
// PWM period / high-time meter with synchroniser, optional glitch filter and timeout.
// Define PWM_METER_FILTER_EN to enable the FILTER_LEN-sample glitch filter.
module pwm_meter #(
  parameter int               CNT_W      = 26,
  parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(50_000_000),
  parameter int               FILTER_LEN = 4
) (
  input logic        sys_clk,
  input logic        sys_rst,
  pwm_meter_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic             sync_p0;
  logic             sync_p1;
  logic             cond_p2;
  logic             prev_p3;
  logic             rise;
  logic             fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;

  if (FILTER_LEN < 1) begin : g_filter_len_check
    $error("pwm_meter: FILTER_LEN must be at least 1");
  end

  // Stage p0/p1: two-flop synchroniser for the asynchronous input
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.pwm_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef PWM_METER_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [FW-1:0] flt_cnt;

  // Stage p2: level follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cond_p2 <= 1'b0;
      flt_cnt <= '0;
    end else if (sync_p1 == cond_p2) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      cond_p2 <= sync_p1;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
`else
  assign cond_p2 = sync_p1;
`endif

  // Stage p3: previous conditioned level for edge detection
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prev_p3 <= 1'b0;
    end else begin
      prev_p3 <= cond_p2;
    end
  end

  assign rise = cond_p2 & ~prev_p3;
  assign fall = ~cond_p2 & prev_p3;

  // Measurement FSM; the counter stops at TIMEOUT instead of wrapping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      high_lat   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (cnt == TIMEOUT) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (fall) begin
              high_lat <= cnt;
              state    <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            period_cnt <= cnt;
            high_cnt   <= high_lat;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            cnt        <= CNT_W'(1);
            state      <= ST_HIGH;
          end else if (cnt == TIMEOUT) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.high_cnt   = high_cnt;
  assign bus.period_cnt = period_cnt;
  assign bus.meas_valid = meas_valid;
  assign bus.timeout    = timeout;
  assign bus.level      = cond_p2;

endmodule

// File: tb/tb_pwm_meter.sv
// Self-checking bench for pwm_meter: edge-timestamp reference model, vector table,
// reset / timeout / glitch sequences and randomized duty cycles.
module tb_pwm_meter;
  localparam int CNT_W = 26;
  localparam int TO    = 5000;
  localparam int FLEN  = 4;
`ifdef PWM_METER_FILTER_EN
  localparam int LAT         = 3 + FLEN;
  localparam bit MODEL_GLT   = 1'b0;
  localparam int GL_HIGH     = 500;
  localparam int GL_PERIOD   = 800;
  localparam int GL_NV       = 1;
`else
  localparam int LAT         = 3;
  localparam bit MODEL_GLT   = 1'b1;
  localparam int GL_HIGH     = 248;
  localparam int GL_PERIOD   = 548;
  localparam int GL_NV       = 2;
`endif

  typedef struct {
    longint high;
    longint period;
    longint t_rise;
  } meas_t;

  typedef struct {
    int high;
    int period;
    int reps;
    int exp_high;
    int exp_period;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  longint rise_t = 0;
  longint fall_t = 0;
  longint last_valid_cyc = 0;
  longint prev_valid_cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_valid = 0;
  int     nv0;
  bit     armed = 1'b0;
  bit     have_fall = 1'b0;
  logic   cur_lvl = 1'b0;
  logic   prev_to = 1'b0;
  logic   valid_to = 1'b0;
  logic   valid_prev_to = 1'b0;
  meas_t  exp_q[$];
  vec_t   vecs[4];

  always #5 clk = ~clk;

  pwm_meter_if #(.CNT_W(CNT_W)) bus ();

  pwm_meter #(
    .CNT_W(CNT_W),
    .TIMEOUT(CNT_W'(TO)),
    .FILTER_LEN(FLEN)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample #1 after the rising edge and score any measurement
  task automatic tick();
    meas_t m;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.meas_valid === 1'b1) begin
      n_valid++;
      valid_to       = bus.timeout;
      valid_prev_to  = prev_to;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      check("meas_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        check("high_cnt", bus.high_cnt, m.high);
        check("period_cnt", bus.period_cnt, m.period);
        check("latency", cyc - m.t_rise, LAT);
      end
    end
    prev_to = bus.timeout;
  endtask

  // Drive pwm_in; when modelled, record edge times and queue the expected measurement
  task automatic set_pwm(input logic v, input bit model);
    if (model && v !== cur_lvl) begin
      if (v) begin
        if (armed && have_fall)
          exp_q.push_back('{fall_t - rise_t, cyc - rise_t, cyc});
        rise_t    = cyc;
        armed     = 1'b1;
        have_fall = 1'b0;
      end else if (armed) begin
        fall_t    = cyc;
        have_fall = 1'b1;
      end
    end
    if (model) cur_lvl = v;
    bus.pwm_in = v;
  endtask

  task automatic run_period(input int h, input int p);
    set_pwm(1'b1, 1'b1);
    repeat (h) tick();
    set_pwm(1'b0, 1'b1);
    repeat (p - h) tick();
  endtask

  task automatic pulse_reset();
    check("queue_empty_at_reset", exp_q.size(), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    armed     = 1'b0;
    have_fall = 1'b0;
    check("rst_high_cnt", bus.high_cnt, 0);
    check("rst_period_cnt", bus.period_cnt, 0);
    check("rst_meas_valid", bus.meas_valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_level", bus.level, 0);
  endtask

  task automatic do_reset();
    set_pwm(1'b0, 1'b1);
    pulse_reset();
    repeat (10) tick();
  endtask

  initial begin
`ifdef PWM_METER_FILTER_EN
    vecs[0] = '{250, 1000, 3, 250, 1000};
    vecs[1] = '{FLEN, 10, 8, FLEN, 10};
    vecs[2] = '{10 - FLEN, 10, 8, 10 - FLEN, 10};
    vecs[3] = '{7, 20, 5, 7, 20};
`else
    vecs[0] = '{250, 1000, 3, 250, 1000};
    vecs[1] = '{1, 10, 8, 1, 10};
    vecs[2] = '{9, 10, 8, 9, 10};
    vecs[3] = '{7, 20, 5, 7, 20};
`endif
    bus.pwm_in = 1'b0;
    repeat (2) tick();
    do_reset();

    // Periodic vectors: the first rise only arms, every further rise measures
    foreach (vecs[i]) begin
      do_reset();
      nv0 = n_valid;
      repeat (vecs[i].reps) run_period(vecs[i].high, vecs[i].period);
      set_pwm(1'b1, 1'b1);
      repeat (LAT + 3) tick();
      check("vec_high_cnt", bus.high_cnt, vecs[i].exp_high);
      check("vec_period_cnt", bus.period_cnt, vecs[i].exp_period);
      check("vec_valid_count", n_valid - nv0, vecs[i].reps);
      check("vec_valid_spacing", last_valid_cyc - prev_valid_cyc, vecs[i].exp_period);
      check("vec_timeout", bus.timeout, 0);
    end

    // Reset in the middle of a low phase discards the reference edge
    do_reset();
    run_period(40, 100);
    run_period(40, 100);
    set_pwm(1'b1, 1'b1);
    repeat (40) tick();
    set_pwm(1'b0, 1'b1);
    repeat (20) tick();
    pulse_reset();
    nv0 = n_valid;
    repeat (40) tick();
    run_period(40, 100);
    check("post_reset_arm_only", n_valid - nv0, 0);
    set_pwm(1'b1, 1'b1);
    repeat (LAT + 3) tick();
    check("post_reset_valid_count", n_valid - nv0, 1);
    check("post_reset_high", bus.high_cnt, 40);
    check("post_reset_period", bus.period_cnt, 100);

    // Timeout: input held high after a complete period
    do_reset();
    run_period(30, 100);
    set_pwm(1'b1, 1'b1);
    for (int k = 0; k < TO + LAT + 20 && bus.timeout !== 1'b1; k++) tick();
    check("timeout_delay", cyc - last_valid_cyc, TO);
    check("timeout_set", bus.timeout, 1);
    check("timeout_hold_high", bus.high_cnt, 30);
    check("timeout_hold_period", bus.period_cnt, 100);
    check("timeout_level", bus.level, 1);
    armed     = 1'b0;
    have_fall = 1'b0;
    set_pwm(1'b0, 1'b1);
    repeat (50) tick();
    nv0 = n_valid;
    run_period(30, 100);
    check("timeout_held_until_valid", bus.timeout, 1);
    set_pwm(1'b1, 1'b1);
    repeat (LAT + 3) tick();
    check("resume_valid_count", n_valid - nv0, 1);
    check("timeout_clear_at_valid", valid_to, 0);
    check("timeout_set_before_valid", valid_prev_to, 1);

    // Two-cycle low glitch inside a 500-cycle high phase
    do_reset();
    nv0 = n_valid;
    set_pwm(1'b1, 1'b1);
    repeat (250) tick();
    set_pwm(1'b0, MODEL_GLT);
    repeat (2) tick();
    set_pwm(1'b1, MODEL_GLT);
    repeat (248) tick();
    set_pwm(1'b0, 1'b1);
    repeat (300) tick();
    set_pwm(1'b1, 1'b1);
    repeat (LAT + 3) tick();
    check("glitch_valid_count", n_valid - nv0, GL_NV);
    check("glitch_high_cnt", bus.high_cnt, GL_HIGH);
    check("glitch_period_cnt", bus.period_cnt, GL_PERIOD);

    // Randomized duty cycles against the edge-timestamp model
    do_reset();
    nv0 = n_valid;
    for (int n = 0; n < 40; n++) begin
      int h;
      int l;
      h = int'($urandom_range(6, 60));
      l = int'($urandom_range(6, 60));
      run_period(h, h + l);
    end
    set_pwm(1'b1, 1'b1);
    repeat (LAT + 3) tick();
    check("random_valid_count", n_valid - nv0, 40);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
